// File: rtl/demux_lane_collector.sv
// demux_lane_collector: rebuilds the two demux output lanes into words.
// Each lane shifts in its steered bits MSB-first. Each finished word goes
// out on that lane's own valid/ready interface. A sticky flag records any
// word that was dropped because the lane's output register was still full.

module demux_lane_collector_lane #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap,
   input  logic             din,
   input  logic             clr,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             ovf,
   output logic [CW-1:0]    cnt
);

   // Only the low WIDTH-1 bits of a partial word ever need storing.
   // The newest bit comes straight from din when the word completes.
   logic [WIDTH-2:0] sh;
   logic [WIDTH-1:0] word;
   logic             done;

   assign word = {sh, din};
   assign done = cap && (cnt == CW'(WIDTH - 1));

   // Partial-word shifter and bit counter; clr wins over a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh  <= '0;
         cnt <= '0;
      end else if (clr) begin
         sh  <= '0;
         cnt <= '0;
      end else if (cap) begin
         sh  <= word[WIDTH-2:0];
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

   // Output register: load on completion if the slot is free or draining, else drop and flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
         ovf   <= 1'b0;
      end else if (done) begin
         if (!valid || ready) begin
            data  <= word;
            valid <= 1'b1;
         end else begin
            ovf <= 1'b1;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

module demux_lane_collector #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     sel,
   input  logic                     y0,
   input  logic                     y1,
   input  logic                     stb,
   input  logic                     clr,
   input  logic                     ready0,
   input  logic                     ready1,
   output logic [WIDTH-1:0]         data0,
   output logic [WIDTH-1:0]         data1,
   output logic                     valid0,
   output logic                     valid1,
   output logic                     ovf0,
   output logic                     ovf1,
   output logic [$clog2(WIDTH)-1:0] cnt0,
   output logic [$clog2(WIDTH)-1:0] cnt1
);

   localparam int CW = $clog2(WIDTH);

   logic cap;
   logic din;

   // A strobed bit is discarded when clr is high in the same cycle.
   assign cap = stb && en && !clr;
   assign din = sel ? y1 : y0;

   demux_lane_collector_lane #(.WIDTH(WIDTH), .CW(CW)) lane0 (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (cap && !sel),
      .din   (din),
      .clr   (clr),
      .ready (ready0),
      .data  (data0),
      .valid (valid0),
      .ovf   (ovf0),
      .cnt   (cnt0)
   );

   demux_lane_collector_lane #(.WIDTH(WIDTH), .CW(CW)) lane1 (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (cap && sel),
      .din   (din),
      .clr   (clr),
      .ready (ready1),
      .data  (data1),
      .valid (valid1),
      .ovf   (ovf1),
      .cnt   (cnt1)
   );

endmodule

// File: tb/tb_demux_lane_collector.sv
// Testbench for demux_lane_collector. Directed scenarios come first,
// followed by a randomized run. Every output is compared each cycle against
// a word-level reference model of the two lanes.

module tb_demux_lane_collector;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          sel;
   logic          y0;
   logic          y1;
   logic          stb;
   logic          clr;
   logic          ready0;
   logic          ready1;
   logic [W-1:0]  data0;
   logic [W-1:0]  data1;
   logic          valid0;
   logic          valid1;
   logic          ovf0;
   logic          ovf1;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;

   int total = 0;
   int bad   = 0;

   // Reference model state: partial value, bits held, output slot, sticky flag
   int m_part  [2];
   int m_cnt   [2];
   int m_data  [2];
   int m_valid [2];
   int m_ovf   [2];

   demux_lane_collector #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sel    (sel),
      .y0     (y0),
      .y1     (y1),
      .stb    (stb),
      .clr    (clr),
      .ready0 (ready0),
      .ready1 (ready1),
      .data0  (data0),
      .data1  (data1),
      .valid0 (valid0),
      .valid1 (valid1),
      .ovf0   (ovf0),
      .ovf1   (ovf1),
      .cnt0   (cnt0),
      .cnt1   (cnt1)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void modelReset();
      for (int k = 0; k < 2; k++) begin
         m_part[k]  = 0;
         m_cnt[k]   = 0;
         m_data[k]  = 0;
         m_valid[k] = 0;
         m_ovf[k]   = 0;
      end
   endfunction

   // One clock edge of the reference model, computed from the inputs that are about to be sampled
   function automatic void modelStep(input logic i_en, input logic i_sel, input logic i_y0, input logic i_y1,
                                     input logic i_stb, input logic i_clr, input logic i_r0, input logic i_r1);
      for (int k = 0; k < 2; k++) begin
         int  rdy;
         int  word;
         int  b;
         bit  done;
         rdy  = (k == 0) ? int'(i_r0) : int'(i_r1);
         done = 1'b0;
         word = 0;
         if (i_clr) begin
            m_part[k] = 0;
            m_cnt[k]  = 0;
         end else if (i_stb && i_en && int'(i_sel) == k) begin
            b         = i_sel ? int'(i_y1) : int'(i_y0);
            m_part[k] = (m_part[k] * 2 + b) % (1 << W);
            m_cnt[k]  = m_cnt[k] + 1;
            if (m_cnt[k] == W) begin
               done      = 1'b1;
               word      = m_part[k];
               m_part[k] = 0;
               m_cnt[k]  = 0;
            end
         end
         if (done) begin
            if (m_valid[k] == 0 || rdy == 1) begin
               m_data[k]  = word;
               m_valid[k] = 1;
            end else begin
               m_ovf[k] = 1;
            end
         end else if (m_valid[k] == 1 && rdy == 1) begin
            m_valid[k] = 0;
         end
      end
   endfunction

   task automatic checkAll();
      checkOutput("data0",  32'(data0),  32'(m_data[0]));
      checkOutput("data1",  32'(data1),  32'(m_data[1]));
      checkOutput("valid0", 32'(valid0), 32'(m_valid[0]));
      checkOutput("valid1", 32'(valid1), 32'(m_valid[1]));
      checkOutput("ovf0",   32'(ovf0),   32'(m_ovf[0]));
      checkOutput("ovf1",   32'(ovf1),   32'(m_ovf[1]));
      checkOutput("cnt0",   32'(cnt0),   32'(m_cnt[0]));
      checkOutput("cnt1",   32'(cnt1),   32'(m_cnt[1]));
   endtask

   // Drive one cycle of inputs, advance the model, then check just after the edge
   task automatic applyStimulus(input logic i_en, input logic i_sel, input logic i_y0, input logic i_y1,
                                input logic i_stb, input logic i_clr, input logic i_r0, input logic i_r1);
      en     = i_en;
      sel    = i_sel;
      y0     = i_y0;
      y1     = i_y1;
      stb    = i_stb;
      clr    = i_clr;
      ready0 = i_r0;
      ready1 = i_r1;
      modelStep(i_en, i_sel, i_y0, i_y1, i_stb, i_clr, i_r0, i_r1);
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic sendBit(input int lane, input logic b, input logic r0, input logic r1);
      logic junk;
      junk = 1'($urandom_range(0, 1));
      if (lane == 0) applyStimulus(1'b1, 1'b0, b, junk, 1'b1, 1'b0, r0, r1);
      else           applyStimulus(1'b1, 1'b1, junk, b, 1'b1, 1'b0, r0, r1);
   endtask

   task automatic sendWord(input int lane, input logic [W-1:0] w, input logic r0, input logic r1);
      for (int i = W - 1; i >= 0; i--) sendBit(lane, w[i], r0, r1);
   endtask

   task automatic idle(input logic r0, input logic r1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r0, r1);
   endtask

   // Async reset asserted between edges; outputs must clear without a clock
   task automatic doReset();
      en = 1'b0; sel = 1'b0; y0 = 1'b0; y1 = 1'b0;
      stb = 1'b0; clr = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
      rst_n = 1'b0;
      #2;
      modelReset();
      checkOutput("rst_data0",  32'(data0),  32'h0);
      checkOutput("rst_data1",  32'(data1),  32'h0);
      checkOutput("rst_valid0", 32'(valid0), 32'h0);
      checkOutput("rst_valid1", 32'(valid1), 32'h0);
      checkOutput("rst_ovf0",   32'(ovf0),   32'h0);
      checkOutput("rst_ovf1",   32'(ovf1),   32'h0);
      checkOutput("rst_cnt0",   32'(cnt0),   32'h0);
      checkOutput("rst_cnt1",   32'(cnt1),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkAll();
   endtask

   initial begin
      logic [W-1:0] w0;
      logic [W-1:0] w1;
      logic [W-1:0] wa;
      int           step;

      doReset();
      idle(1'b0, 1'b0);

      $display("[TB] lane 0 single word");
      sendWord(0, 8'hA5, 1'b1, 1'b0);
      checkOutput("a5_data0",  32'(data0),  32'hA5);
      checkOutput("a5_valid0", 32'(valid0), 32'h1);
      checkOutput("a5_valid1", 32'(valid1), 32'h0);
      checkOutput("a5_cnt0",   32'(cnt0),   32'h0);
      idle(1'b1, 1'b0);
      checkOutput("a5_drain",  32'(valid0), 32'h0);

      $display("[TB] interleaved lanes with enable gaps");
      w0   = 8'h3C;
      w1   = 8'hC3;
      step = 0;
      for (int i = W - 1; i >= 0; i--) begin
         sendBit(0, w0[i], 1'b1, 1'b1);
         if (i == 0) begin
            checkOutput("il_data0",  32'(data0),  32'h3C);
            checkOutput("il_valid0", 32'(valid0), 32'h1);
         end
         step++;
         if (step % 3 == 0) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
         sendBit(1, w1[i], 1'b1, 1'b1);
      end
      checkOutput("il_data1",  32'(data1),  32'hC3);
      checkOutput("il_valid1", 32'(valid1), 32'h1);
      idle(1'b1, 1'b1);

      $display("[TB] lane 1 back-pressure");
      sendWord(1, 8'h11, 1'b1, 1'b0);
      checkOutput("bp_first", 32'(data1), 32'h11);
      sendWord(1, 8'h22, 1'b1, 1'b0);
      checkOutput("bp_data1",  32'(data1),  32'h11);
      checkOutput("bp_valid1", 32'(valid1), 32'h1);
      checkOutput("bp_ovf1",   32'(ovf1),   32'h1);
      idle(1'b1, 1'b1);
      checkOutput("bp_drain", 32'(valid1), 32'h0);
      checkOutput("bp_stick", 32'(ovf1),   32'h1);

      $display("[TB] load and handshake on the same edge");
      sendWord(0, 8'h55, 1'b0, 1'b0);
      wa = 8'hAA;
      for (int i = W - 1; i >= 0; i--) sendBit(0, wa[i], (i == 0) ? 1'b1 : 1'b0, 1'b0);
      checkOutput("se_valid0", 32'(valid0), 32'h1);
      checkOutput("se_data0",  32'(data0),  32'hAA);
      checkOutput("se_ovf0",   32'(ovf0),   32'h0);
      idle(1'b1, 1'b0);

      $display("[TB] clear and reset mid-word");
      for (int i = 0; i < 5; i++) sendBit(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("clr_cnt0", 32'(cnt0), 32'h0);
      sendWord(0, 8'hF0, 1'b1, 1'b0);
      checkOutput("clr_data0", 32'(data0), 32'hF0);
      for (int i = 0; i < 3; i++) sendBit(0, 1'b1, 1'b0, 1'b0);
      doReset();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) doReset();
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                       1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_lane_collector.md
Name: demux_lane_collector

Overview:
- Downstream stage of the 1-to-2 demultiplexer; consumes its two output lanes y0/y1 together with the sel/en steering that produced them.
- Each lane is deserialised independently, MSB-first, into a WIDTH-bit word.
- Each completed word is presented on a per-lane valid/ready output interface.
- A per-lane sticky overflow flag records words dropped because the lane's output register was still occupied.

Parameters:
WIDTH, 8, bits per assembled word per lane; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  demux enable; strobes ignored while low
sel  input  1  lane select from demux steering; 0 = lane 0 (y0), 1 = lane 1 (y1)
y0  input  1  demux output lane 0
y1  input  1  demux output lane 1
stb  input  1  bit strobe; one bit captured per cycle with stb=1 and en=1
clr  input  1  synchronous clear of partial words and counters
ready0  input  1  lane 0 consumer ready
ready1  input  1  lane 1 consumer ready
data0  output  WIDTH  lane 0 assembled word
data1  output  WIDTH  lane 1 assembled word
valid0  output  1  lane 0 word valid
valid1  output  1  lane 1 word valid
ovf0  output  1  lane 0 sticky overflow
ovf1  output  1  lane 1 sticky overflow
cnt0  output  clog2(WIDTH)  lane 0 bits currently held in partial word
cnt1  output  clog2(WIDTH)  lane 1 bits currently held in partial word

Behaviour:
- Reset (rst_n=0, asynchronous): all shift registers, counters, data0/1, valid0/1 and ovf0/1 go to 0. Outputs remain 0 until the first clock edge after rst_n deasserts.
- Capture condition: stb && en at a rising edge. The captured bit is y1 when sel=1, else y0. Only lane[sel] updates; the other lane holds.
- Shift: sh[k] <= {sh[k][WIDTH-2:0], bit}, MSB-first; cnt[k] <= cnt[k]+1.
- Word completion: on a capture with cnt[k]==WIDTH-1, word = {sh[k][WIDTH-2:0], bit} and cnt[k] wraps to 0.
- Output load: if valid[k]==0, or ready[k]==1 in the same cycle, then data[k] <= word and valid[k] <= 1. Latency is 1 cycle: valid rises on the edge that captures the WIDTH-th bit.
- Overflow: if valid[k]==1 and ready[k]==0 at completion, the word is dropped and ovf[k] <= 1. data[k] is unchanged.
- ovf[k] clears only on reset. clr does not affect ovf[k].
- Handshake: a transfer occurs on an edge with valid[k] && ready[k]. valid[k] then drops unless a new word loads on the same edge, in which case valid stays 1 with the new data.
- data[k] is stable while valid[k]=1 and ready[k]=0.
- en=0 or stb=0: no capture; partial words and counts are held indefinitely. The handshake still operates.
- clr=1 (synchronous, priority over capture): sh[0], sh[1], cnt0, cnt1 go to 0 and any bit strobed that cycle is discarded. data/valid/ovf are unaffected, so a pending word can still be consumed.
- Lanes are fully independent. Simultaneous completion on one lane and a handshake on the other is legal.
- Asserting rst_n mid-word discards partial words and any pending output words.

Test Plan:
- Reset/idle: rst_n=0 then release, no stb → data0/1=0x00, valid0/1=0, ovf0/1=0, cnt0/1=0.
- Lane 0 word: en=1, sel=0, stb for 8 cycles with y0=1,0,1,0,0,1,0,1 and ready0=1 → valid0=1 for one cycle after the 8th edge, data0=0xA5, valid1=0, cnt0 back to 0.
- Interleave: alternate sel=0/1 every strobe; lane 0 bits give 0x3C, lane 1 bits give 0xC3 → data0=0x3C and data1=0xC3, each valid pulse after its lane's 8th bit; en=0 gaps mid-word do not change the results.
- Back-pressure/overflow: ready1=0, complete two lane-1 words 0x11 then 0x22 → data1 stays 0x11 with valid1=1, ovf1=1 at the second completion; raising ready1 transfers 0x11, then valid1=0.
- Same-edge load+handshake: valid0=1 holding 0x55 and ready0=1 on the edge that completes 0xAA → valid0 stays 1, data0=0xAA, ovf0=0.
- clr/reset mid-word: 5 bits on lane 0, then clr=1 for one cycle → cnt0=0; 8 further bits 0xF0 yield data0=0xF0. Repeat with rst_n pulsed low mid-word → all outputs immediately 0.
